// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter states, byte width
// and the index-width helper used for requester ids.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_arb_state_e;

    // Width of an index able to name n requesters (never narrower than 1 bit).
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1 with wrap-around. Returns a one-hot grant, its index and an any flag.
module rr_picker
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = grant_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the N candidates in priority order; the first hit wins.
    always_comb begin
        int  j;
        logic hit;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        hit   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j        = (int'(ptr) + k) % N;
            hit      = req[j] & ~found;
            grant[j] = hit;
            idx      = hit ? IW'(j) : idx;
            found    = found | hit;
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers.
// Optional packet lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 15,
    localparam int GW          = grant_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [GW-1:0]             grant_id,
    output logic                      active,
    output logic                      timeout_err
);

    tx_arb_state_e     state_r;
    logic [GW-1:0]     ptr_r;
    logic [7:0]        cnt_r;
    logic [BYTE_W-1:0] tx_data_r;
    logic              tx_start_r;
    logic [GW-1:0]     grant_id_r;
    logic              active_r;
    logic              timeout_err_r;

    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] pick_grant_s;
    logic [GW-1:0]      pick_idx_s;
    logic               pick_any_s;
    logic               can_grant_s;
    logic [BYTE_W-1:0]  win_data_s;

`ifdef UART_TX_ARB_LOCK_EN
    logic               lock_r;
    logic [GW-1:0]      lock_id_r;
    logic [NUM_REQ-1:0] lock_mask_s;

    // While a packet is open only its owner may be considered.
    always_comb begin
        lock_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << lock_id_r;
        if (lock_r) begin
            eligible_s = req_valid & lock_mask_s;
        end else begin
            eligible_s = req_valid;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = ^req_last;
    assign eligible_s    = req_valid;
`endif

    rr_picker #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_picker (
        .req   (eligible_s),
        .ptr   (ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Grant only from IDLE with the transmitter quiet, and never during reset.
    always_comb begin
        can_grant_s = rst && (state_r == IDLE) && !tx_busy && pick_any_s;
        win_data_s  = req_data[int'(pick_idx_s)*BYTE_W +: BYTE_W];
        if (can_grant_s) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Arbitration FSM with data latch, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            ptr_r         <= GW'(NUM_REQ - 1);
            cnt_r         <= 8'd0;
            tx_data_r     <= '0;
            tx_start_r    <= 1'b0;
            grant_id_r    <= '0;
            active_r      <= 1'b0;
            timeout_err_r <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_r        <= 1'b0;
            lock_id_r     <= '0;
`endif
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (can_grant_s) begin
                        tx_data_r  <= win_data_s;
                        grant_id_r <= pick_idx_s;
                        ptr_r      <= pick_idx_s;
                        tx_start_r <= 1'b1;
                        active_r   <= 1'b1;
                        state_r    <= START;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_r     <= ~req_last[pick_idx_s];
                        lock_id_r  <= pick_idx_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    cnt_r   <= 8'd0;
                    state_r <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state_r <= WAIT_LO;
                    end else if ((cnt_r + 8'd1) == 8'(BUSY_TIMEOUT)) begin
                        // Transmitter never acknowledged: drop the byte.
                        timeout_err_r <= 1'b1;
                        active_r      <= 1'b0;
                        state_r       <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_r        <= 1'b0;
`endif
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        active_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= WAIT_LO;
                    end
                end
                default: begin
                    active_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_r;
    assign tx_start    = tx_start_r;
    assign grant_id    = grant_id_r;
    assign active      = active_r;
    assign timeout_err = timeout_err_r;

endmodule
